reset_sequencer: RTL and testbench

- Sits between the clock wizard, button parser and CPU in the top level.
- Generates the CPU reset only after the PLL lock has been stable for a programmable time, and stretches each user reset request into a fixed-length reset pulse.
- Re-enters reset automatically on loss of lock, and counts user-initiated resets for status display.

---
 rtl/reset_sequencer_pkg.sv | 24 ++
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_sequencer_sync_2ff.sv | 35 +++
 rtl/reset_sequencer.sv | 127 ++++++++++++
 tb/tb_reset_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
// Holds the state encoding, the state width, the default timing parameters
// derived from the nominal CPU clock, and a counter-width helper.
package reset_sequencer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StWaitLock = 2'd0,
        StHold     = 2'd1,
        StRun      = 2'd2
    } state_e;

    // Nominal CPU clock; lock must be stable for 4 us and the pulse lasts 1 us.
    localparam int unsigned CPU_CLK_MHZ                = 16;
    localparam int unsigned DEFAULT_LOCK_STABLE_CYCLES = CPU_CLK_MHZ * 4;
    localparam int unsigned DEFAULT_HOLD_CYCLES        = CPU_CLK_MHZ;

    // Wide enough to hold the value n itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the button parser / status display and the
// reset sequencer.
//   rst_req   : single-cycle user reset request
//   arm       : level enable qualifying rst_req
//   cpu_rst   : active-high CPU reset
//   busy      : high whenever the sequencer is not in RUN
//   state_o   : current state encoding
//   rst_count : saturating count of accepted user resets
interface reset_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                                      rst_req;
    logic                                      arm;
    logic                                      cpu_rst;
    logic                                      busy;
    logic [reset_sequencer_pkg::STATE_W-1:0]   state_o;
    logic [CNT_WIDTH-1:0]                      rst_count;

    modport master (
        output rst_req, arm,
        input  cpu_rst, busy, state_o, rst_count
    );

    modport slave (
        input  rst_req, arm,
        output cpu_rst, busy, state_o, rst_count
    );

endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous level signals.
//   clk : destination clock
//   rst : synchronous active-low reset, clears both stages
//   d_i : asynchronous input
//   q_o : synchronized output, two cycles behind d_i
module reset_sequencer_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// CPU reset sequencer.
// Holds the CPU in reset until the PLL lock has been stable for
// LOCK_STABLE_CYCLES, stretches accepted user requests into a HOLD_CYCLES
// pulse, drops back to waiting on any loss of lock and counts user resets.
//   clk        : CPU clock
//   rst        : synchronous active-low block reset
//   pll_locked : clock wizard lock flag, asynchronous to clk
//   bus        : request inputs and status outputs (slave side)
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEFAULT_LOCK_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES        = DEFAULT_HOLD_CYCLES,
    parameter int unsigned CNT_WIDTH          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    reset_sequencer_if.slave  bus
);

    localparam int unsigned LockW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam logic [LockW-1:0] LockTarget = LockW'(LOCK_STABLE_CYCLES);
    localparam logic [HoldW-1:0] HoldLast   = HoldW'(HOLD_CYCLES - 1);

    logic                 lock_s;
    logic                 req_acc;
    state_e               state_q, state_d;
    logic [LockW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0] rst_count_q, rst_count_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 busy_q, busy_d;

    reset_sequencer_sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lock_s)
    );

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rst_count_d = rst_count_q;
        req_acc     = bus.rst_req & bus.arm;

        case (state_q)
            StWaitLock: begin
                hold_cnt_d = '0;
                if (!lock_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LockTarget) begin
                    state_d    = StHold;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LockW'(1);
                end
            end
            StHold: begin
                // Lock loss wins over a simultaneous request.
                if (!lock_s) begin
                    state_d    = StWaitLock;
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                end else if (req_acc) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d    = StWaitLock;
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                end else if (req_acc) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                    if (rst_count_q != '1) begin
                        rst_count_d = rst_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d    = StWaitLock;
                lock_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase

        // Registered from the next state so the pulse edges line up with state_o.
        cpu_rst_d = (state_d != StRun);
        busy_d    = (state_d != StRun);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StWaitLock;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            rst_count_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_count_q <= rst_count_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.busy      = busy_q;
    assign bus.state_o   = state_q;
    assign bus.rst_count = rst_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a time-based reference model
// predicts the outputs after every clock edge into a queue, and a monitor
// pops and compares them on the falling edge. Directed checks cover the
// release latency, pulse lengths and counter boundaries.
module tb_reset_sequencer;

    localparam int L = 64;
    localparam int H = 16;
    localparam int PhWait = 0;
    localparam int PhHold = 1;
    localparam int PhRun  = 2;

    logic clk;
    logic rst;
    logic pll_locked;

    reset_sequencer_if #(.CNT_WIDTH(8)) bus ();

    reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .HOLD_CYCLES        (H),
        .CNT_WIDTH          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .bus        (bus)
    );

    typedef struct packed {
        logic       cpu_rst;
        logic       busy;
        logic [1:0] state;
        logic [7:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: absolute-time deadlines instead of counters.
    int   m_phase      = PhWait;
    int   m_lock_since = -1;
    int   m_release_at = 0;
    int   m_cyc        = 0;
    int   m_count      = 0;
    logic hist[$]      = '{1'b0, 1'b0};

    initial begin
        logic ls;
        logic req;
        exp_t e;
        forever begin
            @(posedge clk);
            m_cyc++;
            if (!rst) begin
                m_phase      = PhWait;
                m_lock_since = -1;
                m_count      = 0;
                hist         = '{1'b0, 1'b0};
            end else begin
                ls = hist[1];
                hist.push_front(pll_locked);
                void'(hist.pop_back());
                req = bus.rst_req && bus.arm;
                case (m_phase)
                    PhWait: begin
                        if (!ls) m_lock_since = -1;
                        else if (m_lock_since < 0) m_lock_since = m_cyc;
                        else if (m_cyc - m_lock_since == L) begin
                            m_phase      = PhHold;
                            m_release_at = m_cyc + H;
                        end
                    end
                    PhHold: begin
                        if (!ls) begin
                            m_phase      = PhWait;
                            m_lock_since = -1;
                        end else if (req) m_release_at = m_cyc + H;
                        else if (m_cyc == m_release_at) m_phase = PhRun;
                    end
                    default: begin
                        if (!ls) begin
                            m_phase      = PhWait;
                            m_lock_since = -1;
                        end else if (req) begin
                            m_phase      = PhHold;
                            m_release_at = m_cyc + H;
                            if (m_count < 255) m_count++;
                        end
                    end
                endcase
            end
            e.cpu_rst = (m_phase != PhRun);
            e.busy    = (m_phase != PhRun);
            e.state   = 2'(m_phase);
            e.count   = 8'(m_count);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every predicted cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cpu_rst", 32'(bus.cpu_rst), 32'(e.cpu_rst));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("state_o", 32'(bus.state_o), 32'(e.state));
                check("rst_count", 32'(bus.rst_count), 32'(e.count));
            end
        end
    end

    // Length of the most recent completed cpu_rst high run.
    int hi_cnt   = 0;
    int last_len = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cpu_rst === 1'b1) hi_cnt++;
            else if (hi_cnt > 0) begin
                last_len = hi_cnt;
                hi_cnt   = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic armed);
        bus.rst_req = 1'b1;
        bus.arm     = armed;
        @(negedge clk);
        bus.rst_req = 1'b0;
        bus.arm     = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (bus.state_o !== 2'd2 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_run", 32'(bus.state_o), 32'd2);
    endtask

    initial begin
        int n;
        rst         = 1'b0;
        pll_locked  = 1'b1;
        bus.rst_req = 1'b0;
        bus.arm     = 1'b0;

        // Power-up.
        cycles(5);
        check("reset_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd1);
        check("reset_state", 32'(bus.state_o), 32'd0);
        check("reset_count", 32'(bus.rst_count), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        n = 0;
        #1;
        while (bus.cpu_rst === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("release_cycle", 32'(n), 32'd82);
        check("release_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // User reset.
        pulse(1'b1);
        wait_run(40);
        cycles(1);
        check("user_pulse_len", 32'(last_len), 32'd16);
        check("user_count", 32'(bus.rst_count), 32'd1);

        // Unarmed request.
        pulse(1'b0);
        cycles(3);
        check("unarmed_state", 32'(bus.state_o), 32'd2);
        check("unarmed_count", 32'(bus.rst_count), 32'd1);

        // Retrigger 10 cycles into HOLD.
        pulse(1'b1);
        cycles(9);
        pulse(1'b1);
        wait_run(60);
        cycles(1);
        check("retrigger_len", 32'(last_len), 32'd26);
        check("retrigger_count", 32'(bus.rst_count), 32'd2);

        // One-cycle lock glitch.
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        n = 1;
        while (bus.cpu_rst !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("glitch_latency", 32'(n), 32'd3);
        check("glitch_state", 32'(bus.state_o), 32'd0);
        wait_run(200);
        cycles(1);
        check("glitch_len", 32'(last_len), 32'd81);

        // Lock chatter never long enough to release.
        for (int i = 0; i < 9; i++) begin
            pll_locked = (i % 2 == 1);
            cycles(30);
        end
        check("chatter_state", 32'(bus.state_o), 32'd0);
        check("chatter_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        pll_locked = 1'b1;
        wait_run(200);

        // Lock loss coincident with an armed request.
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        pulse(1'b1);
        check("simul_state", 32'(bus.state_o), 32'd0);
        wait_run(200);
        check("simul_count", 32'(bus.rst_count), 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            pll_locked  = ($urandom_range(0, 399) != 0);
            bus.rst_req = ($urandom_range(0, 19) == 0);
            bus.arm     = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        pll_locked  = 1'b1;
        bus.rst_req = 1'b0;
        bus.arm     = 1'b0;
        wait_run(300);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            pulse(1'b1);
            cycles(17);
        end
        check("sat_count", 32'(bus.rst_count), 32'd255);

        // Block reset in HOLD.
        pulse(1'b1);
        cycles(5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_state", 32'(bus.state_o), 32'd0);
        check("midrst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("midrst_count", 32'(bus.rst_count), 32'd0);
        wait_run(200);

        cycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
